// File: rtl/axi_slv_burst_mem_if.sv
// AXI4 bus bundle for axi_slv_burst_mem.
//   slave modport : memory side (drives ready on AR/AW/W, drives R and B)
//   master modport: fabric side (drives AR/AW/W, ready on R and B)
interface axi_slv_burst_mem_if #(
   parameter int DW   = 64,
   parameter int TAGW = 1
);
   localparam int NB = DW / 8;

   logic            arvalid, arready;
   logic [31:0]     araddr;
   logic [TAGW-1:0] arid;
   logic [7:0]      arlen;
   logic [1:0]      arburst;

   logic            rvalid, rready;
   logic [DW-1:0]   rdata;
   logic [1:0]      rresp;
   logic [TAGW-1:0] rid;
   logic            rlast;

   logic            awvalid, awready;
   logic [31:0]     awaddr;
   logic [TAGW-1:0] awid;
   logic [7:0]      awlen;
   logic [1:0]      awburst;

   logic            wvalid, wready;
   logic [DW-1:0]   wdata;
   logic [NB-1:0]   wstrb;
   logic            wlast;

   logic            bvalid, bready;
   logic [1:0]      bresp;
   logic [TAGW-1:0] bid;

   modport slave (
      input  arvalid, araddr, arid, arlen, arburst, rready,
             awvalid, awaddr, awid, awlen, awburst,
             wvalid, wdata, wstrb, wlast, bready,
      output arready, rvalid, rdata, rresp, rid, rlast,
             awready, wready, bvalid, bresp, bid
   );

   modport master (
      output arvalid, araddr, arid, arlen, arburst, rready,
             awvalid, awaddr, awid, awlen, awburst,
             wvalid, wdata, wstrb, wlast, bready,
      input  arready, rvalid, rdata, rresp, rid, rlast,
             awready, wready, bvalid, bresp, bid
   );
endinterface

// File: rtl/axi_slv_burst_mem.sv
// AXI4 slave burst memory: FIXED/INCR/WRAP bursts, one outstanding read and
// one outstanding write (independent engines), programmable read latency,
// SLVERR for out-of-window beats and illegal burst encodings.
// Ports:
//   aclk : clock, all logic on posedge
//   rst  : synchronous active-high reset (memory contents are kept)
//   axi  : AXI4 bus, slave modport of axi_slv_burst_mem_if
module axi_slv_burst_mem #(
   parameter int          DW        = 64,
   parameter int          TAGW      = 1,
   parameter logic [31:0] BASE_ADDR = 32'hD0580000,
   parameter int          DEPTH     = 8192,
   parameter int          RD_LAT    = 1
) (
   input logic                aclk,
   input logic                rst,
   axi_slv_burst_mem_if.slave axi
);
   localparam int NB  = DW / 8;
   localparam int LNB = $clog2(NB);
   localparam int IW  = $clog2(DEPTH);

   localparam logic [1:0] B_FIXED = 2'b00;
   localparam logic [1:0] B_INCR  = 2'b01;
   localparam logic [1:0] B_WRAP  = 2'b10;
   localparam logic [1:0] R_OKAY  = 2'b00;
   localparam logic [1:0] R_SLV   = 2'b10;

   logic [DW-1:0] mem [DEPTH];

   // Beat is rejected for a reserved burst, a WRAP length AXI does not allow,
   // or an address outside the window.
   function automatic logic beat_err(input logic [31:0] addr, input logic [1:0] burst,
                                     input logic [7:0] len);
      logic [31:0] off;
      off = addr - BASE_ADDR;
      beat_err = (burst == 2'b11) ||
                 (burst == B_WRAP && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) ||
                 (addr < BASE_ADDR) || ((off >> LNB) >= 32'(DEPTH));
   endfunction

   function automatic logic [IW-1:0] word_idx(input logic [31:0] addr);
      word_idx = IW'((addr - BASE_ADDR) >> LNB);
   endfunction

   // WRAP stays inside the (len+1)*NB container aligned to its own size.
   function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst,
                                             input logic [7:0] len);
      logic [31:0] size;
      logic [31:0] a;
      size = (32'(len) + 32'd1) << LNB;
      a    = addr & ~32'(NB - 1);
      case (burst)
         B_FIXED: next_addr = addr;
         B_INCR:  next_addr = addr + 32'(NB);
         B_WRAP:  next_addr = (a & ~(size - 32'd1)) | ((a + 32'(NB)) & (size - 32'd1));
         default: next_addr = addr;
      endcase
   endfunction

   // ---------------------------------------------------------------- read
   typedef enum logic [1:0] {R_IDLE, R_LAT, R_BEAT} rstate_e;

   rstate_e         rstate_q;
   logic [31:0]     raddr_q, raddr_d, rpres_addr;
   logic [7:0]      rlen_q, rcnt_q, rpres_cnt;
   logic [1:0]      rburst_q;
   logic [3:0]      rlat_q;
   logic [TAGW-1:0] rid_q;
   logic            arready_q, rvalid_q, rlast_q;
   logic [1:0]      rresp_q;
   logic [DW-1:0]   rdata_q;
   logic            rpres_err, r_present;
   logic [IW-1:0]   rpres_idx;

   // The beat to put on the bus: first beat at the end of R_LAT, otherwise
   // the successor of the current beat when it is accepted.
   always_comb begin
      raddr_d    = next_addr(raddr_q, rburst_q, rlen_q);
      rpres_addr = (rstate_q == R_BEAT) ? raddr_d : raddr_q;
      rpres_cnt  = (rstate_q == R_BEAT) ? rcnt_q - 8'd1 : rcnt_q;
      rpres_err  = beat_err(rpres_addr, rburst_q, rlen_q);
      rpres_idx  = word_idx(rpres_addr);
      r_present  = (rstate_q == R_LAT && rlat_q == 4'd0) ||
                   (rstate_q == R_BEAT && axi.rready && rcnt_q != 8'd0);
   end

   always_ff @(posedge aclk) begin
      if (rst) begin
         rstate_q  <= R_IDLE;
         arready_q <= 1'b1;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rresp_q   <= R_OKAY;
         rdata_q   <= '0;
         rid_q     <= '0;
         raddr_q   <= '0;
         rlen_q    <= '0;
         rcnt_q    <= '0;
         rburst_q  <= B_FIXED;
         rlat_q    <= '0;
      end else begin
         case (rstate_q)
            R_IDLE: if (axi.arvalid) begin
               raddr_q   <= axi.araddr;
               rid_q     <= axi.arid;
               rlen_q    <= axi.arlen;
               rburst_q  <= axi.arburst;
               rcnt_q    <= axi.arlen;
               rlat_q    <= 4'(RD_LAT - 1);
               arready_q <= 1'b0;
               rstate_q  <= R_LAT;
            end
            R_LAT: if (rlat_q != 4'd0) rlat_q <= rlat_q - 4'd1;
                   else                rstate_q <= R_BEAT;
            R_BEAT: if (axi.rready && rcnt_q == 8'd0) begin
               rvalid_q  <= 1'b0;
               rlast_q   <= 1'b0;
               arready_q <= 1'b1;
               rstate_q  <= R_IDLE;
            end
            default: rstate_q <= R_IDLE;
         endcase
         // Memory is sampled here, before any same-cycle write lands.
         if (r_present) begin
            raddr_q  <= rpres_addr;
            rcnt_q   <= rpres_cnt;
            rvalid_q <= 1'b1;
            rlast_q  <= (rpres_cnt == 8'd0);
            rresp_q  <= rpres_err ? R_SLV : R_OKAY;
            rdata_q  <= rpres_err ? '0 : mem[rpres_idx];
         end
      end
   end

   // --------------------------------------------------------------- write
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;

   wstate_e         wstate_q;
   logic [31:0]     waddr_q, waddr_d;
   logic [7:0]      wlen_q, wcnt_q;
   logic [1:0]      wburst_q;
   logic [TAGW-1:0] bid_q;
   logic            awready_q, wready_q, bvalid_q, werr_q;
   logic [1:0]      bresp_q;
   logic            w_err, w_bad, w_commit;
   logic [IW-1:0]   w_idx;

   always_comb begin
      waddr_d  = next_addr(waddr_q, wburst_q, wlen_q);
      w_err    = beat_err(waddr_q, wburst_q, wlen_q);
      w_idx    = word_idx(waddr_q);
      // awlen sets the beat count; wlast disagreeing with it only flags an error
      w_bad    = w_err || (axi.wlast != (wcnt_q == 8'd0));
      w_commit = !rst && wstate_q == W_DATA && axi.wvalid && !w_err;
   end

   always_ff @(posedge aclk) begin
      if (rst) begin
         wstate_q  <= W_IDLE;
         awready_q <= 1'b1;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= R_OKAY;
         bid_q     <= '0;
         werr_q    <= 1'b0;
         waddr_q   <= '0;
         wlen_q    <= '0;
         wcnt_q    <= '0;
         wburst_q  <= B_FIXED;
      end else begin
         case (wstate_q)
            W_IDLE: if (axi.awvalid) begin
               waddr_q   <= axi.awaddr;
               bid_q     <= axi.awid;
               wlen_q    <= axi.awlen;
               wburst_q  <= axi.awburst;
               wcnt_q    <= axi.awlen;
               werr_q    <= 1'b0;
               awready_q <= 1'b0;
               wready_q  <= 1'b1;
               wstate_q  <= W_DATA;
            end
            W_DATA: if (axi.wvalid) begin
               if (wcnt_q == 8'd0) begin
                  wready_q <= 1'b0;
                  bvalid_q <= 1'b1;
                  bresp_q  <= (werr_q || w_bad) ? R_SLV : R_OKAY;
                  wstate_q <= W_RESP;
               end else begin
                  werr_q  <= werr_q || w_bad;
                  waddr_q <= waddr_d;
                  wcnt_q  <= wcnt_q - 8'd1;
               end
            end
            W_RESP: if (axi.bready) begin
               bvalid_q  <= 1'b0;
               awready_q <= 1'b1;
               wstate_q  <= W_IDLE;
            end
            default: wstate_q <= W_IDLE;
         endcase
      end
   end

   // Storage kept out of the reset block so contents survive rst.
   always_ff @(posedge aclk) begin
      if (w_commit) begin
         for (int b = 0; b < NB; b++) begin
            if (axi.wstrb[b]) mem[w_idx][b*8 +: 8] <= axi.wdata[b*8 +: 8];
         end
      end
   end

   assign axi.arready = arready_q;
   assign axi.rvalid  = rvalid_q;
   assign axi.rdata   = rdata_q;
   assign axi.rresp   = rresp_q;
   assign axi.rid     = rid_q;
   assign axi.rlast   = rlast_q;
   assign axi.awready = awready_q;
   assign axi.wready  = wready_q;
   assign axi.bvalid  = bvalid_q;
   assign axi.bresp   = bresp_q;
   assign axi.bid     = bid_q;
endmodule

// File: tb/tb_axi_slv_burst_mem.sv
// Directed bench for axi_slv_burst_mem (DW=64, RD_LAT=4): a table of single
// transactions plus hand sequences for stall, wlast errors, reset mid-burst
// and simultaneous AR/AW.
module tb_axi_slv_burst_mem;
   localparam int          RD_LAT = 4;
   localparam logic [31:0] BASE   = 32'hD0580000;
   localparam logic [1:0]  FIX = 2'b00, INC = 2'b01, WRP = 2'b10, RSV = 2'b11;
   localparam logic [1:0]  OK = 2'b00, SLV = 2'b10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   axi_slv_burst_mem_if #(.DW(64), .TAGW(1)) axi ();

   axi_slv_burst_mem #(.DW(64), .TAGW(1), .BASE_ADDR(BASE), .DEPTH(8192), .RD_LAT(RD_LAT)) dut (
      .aclk(clk),
      .rst (rst),
      .axi (axi)
   );

   typedef struct {
      bit               wr;
      logic [31:0]      addr;
      logic [7:0]       len;
      logic [1:0]       burst;
      logic [7:0]       strb;
      logic [3:0][63:0] d;
      logic [1:0]       resp;
   } vec_t;

   function automatic logic [3:0][63:0] dv(input logic [63:0] a, b, c, e);
      dv = {e, c, b, a};
   endfunction

   function automatic vec_t mk(input bit wr, input logic [31:0] a, input logic [7:0] l,
                               input logic [1:0] b, input logic [7:0] s,
                               input logic [3:0][63:0] d, input logic [1:0] r);
      mk.wr = wr; mk.addr = a; mk.len = l; mk.burst = b; mk.strb = s; mk.d = d; mk.resp = r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic timeout(input string nm);
      checks++;
      failures++;
      $display("FAIL %s_timeout", nm);
   endtask

   task automatic axi_write(input string nm, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [7:0] strb,
                            input logic [3:0][63:0] d, input logic id, input int last_at,
                            output logic [1:0] resp);
      int n;
      @(negedge clk);
      axi.awaddr = addr; axi.awlen = len; axi.awburst = burst; axi.awid = id; axi.awvalid = 1'b1;
      n = 0;
      while (!axi.awready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) timeout({nm, "_aw"});
      @(negedge clk);
      axi.awvalid = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         axi.wdata = d[i % 4]; axi.wstrb = strb; axi.wlast = (i == last_at); axi.wvalid = 1'b1;
         n = 0;
         while (!axi.wready && n < 100) begin @(negedge clk); n++; end
         if (n >= 100) timeout({nm, "_w"});
         @(negedge clk);
      end
      axi.wvalid = 1'b0; axi.wlast = 1'b0;
      axi.bready = 1'b1;
      n = 0;
      while (!axi.bvalid && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) timeout({nm, "_b"});
      resp = axi.bresp;
      chk({nm, "_bid"}, 64'(axi.bid), 64'(id));
      @(negedge clk);
      axi.bready = 1'b0;
   endtask

   // Checks latency, every beat (data/resp/last/id, no bubbles) and the
   // return to idle. stall>=0 holds rready low for 3 cycles on that beat.
   task automatic axi_read(input string nm, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic id,
                           input logic [3:0][63:0] d, input logic [1:0] resp, input int stall);
      int n;
      @(negedge clk);
      axi.araddr = addr; axi.arlen = len; axi.arburst = burst; axi.arid = id;
      axi.arvalid = 1'b1; axi.rready = 1'b1;
      n = 0;
      while (!axi.arready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) timeout({nm, "_ar"});
      @(negedge clk);
      axi.arvalid = 1'b0;
      n = 0;
      while (!axi.rvalid && n < 50) begin @(negedge clk); n++; end
      chk({nm, "_lat"}, 64'(n), 64'(RD_LAT));
      for (int i = 0; i <= int'(len); i++) begin
         chk({nm, "_rvalid"}, 64'(axi.rvalid), 64'd1);
         chk({nm, "_rdata"},  axi.rdata, d[i % 4]);
         chk({nm, "_rresp"},  64'(axi.rresp), 64'(resp));
         chk({nm, "_rlast"},  64'(axi.rlast), 64'(i == int'(len)));
         chk({nm, "_rid"},    64'(axi.rid), 64'(id));
         if (i == stall) begin
            axi.rready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               chk({nm, "_stall_valid"}, 64'(axi.rvalid), 64'd1);
               chk({nm, "_stall_data"},  axi.rdata, d[i % 4]);
               chk({nm, "_stall_rid"},   64'(axi.rid), 64'(id));
            end
            axi.rready = 1'b1;
         end
         @(negedge clk);
      end
      chk({nm, "_end_rvalid"},  64'(axi.rvalid), 64'd0);
      chk({nm, "_end_arready"}, 64'(axi.arready), 64'd1);
      axi.rready = 1'b0;
   endtask

   vec_t        tbl [17];
   logic [1:0]  br;
   int          n;

   initial begin
      #2000000;
      $display("FAIL watchdog");
      $fatal(1, "watchdog");
   end

   initial begin
      axi.arvalid = 0; axi.araddr = 0; axi.arid = 0; axi.arlen = 0; axi.arburst = 0; axi.rready = 0;
      axi.awvalid = 0; axi.awaddr = 0; axi.awid = 0; axi.awlen = 0; axi.awburst = 0;
      axi.wvalid = 0; axi.wdata = 0; axi.wstrb = 0; axi.wlast = 0; axi.bready = 0;

      tbl[0]  = mk(1, BASE,          3, INC, 8'hFF, dv(1, 2, 3, 4), OK);
      tbl[1]  = mk(0, BASE,          3, INC, 8'hFF, dv(1, 2, 3, 4), OK);
      tbl[2]  = mk(0, BASE + 32'h18, 3, WRP, 8'hFF, dv(4, 1, 2, 3), OK);
      tbl[3]  = mk(0, BASE,          2, WRP, 8'hFF, dv(0, 0, 0, 0), SLV);
      tbl[4]  = mk(1, BASE + 32'h20, 0, INC, 8'hFF, dv(64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0), OK);
      tbl[5]  = mk(1, BASE + 32'h20, 0, INC, 8'h0F, dv(0, 0, 0, 0), OK);
      tbl[6]  = mk(0, BASE + 32'h20, 0, INC, 8'hFF, dv(64'hFFFF_FFFF_0000_0000, 0, 0, 0), OK);
      tbl[7]  = mk(1, BASE + 32'h28, 1, FIX, 8'hFF, dv(5, 6, 0, 0), OK);
      tbl[8]  = mk(0, BASE + 32'h28, 1, FIX, 8'hFF, dv(6, 6, 0, 0), OK);
      tbl[9]  = mk(0, BASE + 32'h10000, 1, INC, 8'hFF, dv(0, 0, 0, 0), SLV);
      tbl[10] = mk(1, BASE + 32'h10000, 0, INC, 8'hFF, dv(64'hDEAD, 0, 0, 0), SLV);
      tbl[11] = mk(0, BASE,          0, INC, 8'hFF, dv(1, 0, 0, 0), OK);
      tbl[12] = mk(1, BASE - 32'h8,  0, INC, 8'hFF, dv(7, 0, 0, 0), SLV);
      tbl[13] = mk(1, BASE,          0, RSV, 8'hFF, dv(9, 0, 0, 0), SLV);
      tbl[14] = mk(0, BASE,          0, INC, 8'hFF, dv(1, 0, 0, 0), OK);
      tbl[15] = mk(0, BASE + 32'h08, 1, WRP, 8'hFF, dv(2, 1, 0, 0), OK);
      tbl[16] = mk(0, BASE,          0, RSV, 8'hFF, dv(0, 0, 0, 0), SLV);

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_arready", 64'(axi.arready), 1);
      chk("rst_awready", 64'(axi.awready), 1);
      chk("rst_wready",  64'(axi.wready), 0);
      chk("rst_rvalid",  64'(axi.rvalid), 0);
      chk("rst_rlast",   64'(axi.rlast), 0);
      chk("rst_bvalid",  64'(axi.bvalid), 0);
      chk("rst_rresp",   64'(axi.rresp), 0);
      chk("rst_bresp",   64'(axi.bresp), 0);
      chk("rst_rdata",   axi.rdata, 0);
      chk("rst_rid",     64'(axi.rid), 0);
      chk("rst_bid",     64'(axi.bid), 0);
      rst = 1'b0;

      for (int i = 0; i < 17; i++) begin
         if (tbl[i].wr) begin
            axi_write($sformatf("vec%0d", i), tbl[i].addr, tbl[i].len, tbl[i].burst, tbl[i].strb,
                      tbl[i].d, i[0], int'(tbl[i].len), br);
            chk($sformatf("vec%0d_bresp", i), 64'(br), 64'(tbl[i].resp));
         end else begin
            axi_read($sformatf("vec%0d", i), tbl[i].addr, tbl[i].len, tbl[i].burst, i[0],
                     tbl[i].d, tbl[i].resp, -1);
         end
      end

      // backpressure on beat 2
      axi_read("stall", BASE, 3, INC, 1'b1, dv(1, 2, 3, 4), OK, 2);

      // early wlast, missing wlast
      axi_write("early_last", BASE + 32'h38, 1, INC, 8'hFF, dv(8, 8, 0, 0), 1'b0, 0, br);
      chk("early_last_bresp", 64'(br), 64'(SLV));
      axi_write("no_last", BASE + 32'h38, 0, INC, 8'hFF, dv(8, 0, 0, 0), 1'b1, 5, br);
      chk("no_last_bresp", 64'(br), 64'(SLV));

      // simultaneous AR and AW
      @(negedge clk);
      axi.araddr = BASE + 32'h30; axi.arlen = 0; axi.arburst = INC; axi.arid = 1'b1; axi.arvalid = 1'b1;
      axi.awaddr = BASE + 32'h30; axi.awlen = 0; axi.awburst = INC; axi.awid = 1'b0; axi.awvalid = 1'b1;
      @(negedge clk);
      chk("dual_arready_low", 64'(axi.arready), 0);
      chk("dual_awready_low", 64'(axi.awready), 0);
      axi.arvalid = 1'b0; axi.awvalid = 1'b0;
      axi.wdata = 64'hAB; axi.wstrb = 8'hFF; axi.wlast = 1'b1; axi.wvalid = 1'b1;
      @(negedge clk);
      axi.wvalid = 1'b0; axi.wlast = 1'b0; axi.bready = 1'b1;
      n = 0;
      while (!axi.bvalid && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) timeout("dual_b");
      chk("dual_bresp", 64'(axi.bresp), 64'(OK));
      @(negedge clk);
      axi.bready = 1'b0;
      n = 0;
      while (!axi.rvalid && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) timeout("dual_r");
      chk("dual_rdata", axi.rdata, 64'hAB);
      chk("dual_rlast", 64'(axi.rlast), 1);
      axi.rready = 1'b1;
      @(negedge clk);
      axi.rready = 1'b0;

      // reset in the middle of an 8-beat read
      axi.araddr = BASE; axi.arlen = 7; axi.arburst = INC; axi.arid = 1'b1;
      axi.arvalid = 1'b1; axi.rready = 1'b1;
      n = 0;
      while (!axi.arready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) timeout("mid_ar");
      @(negedge clk);
      axi.arvalid = 1'b0;
      n = 0;
      while (!axi.rvalid && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) timeout("mid_r");
      for (int i = 0; i < 3; i++) begin
         chk("mid_rdata", axi.rdata, 64'(i + 1));
         @(negedge clk);
      end
      rst = 1'b1; axi.rready = 1'b0;
      @(negedge clk);
      chk("mid_rst_rvalid",  64'(axi.rvalid), 0);
      chk("mid_rst_arready", 64'(axi.arready), 1);
      chk("mid_rst_rlast",   64'(axi.rlast), 0);
      chk("mid_rst_rdata",   axi.rdata, 0);
      rst = 1'b0;
      axi_read("post_rst", BASE + 32'h08, 1, INC, 1'b0, dv(2, 3, 0, 0), OK, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
